// File: rtl/hazard_ctrl.sv
// hazard_ctrl: 5-stage pipeline sequencing (warm-up, stalls, flushes, halt/drain, forwarding); HAZARD_PERF_CNT_EN adds stall/flush counters
module hazard_ctrl #(
    parameter int WARMUP_CYCLES = 4,
    parameter int DRAIN_CYCLES  = 3,
    parameter int CNT_W         = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] rs1_id,
    input  logic [4:0] rs2_id,
    input  logic       use_rs1_id,
    input  logic       use_rs2_id,
    input  logic       halt_id,
    input  logic [4:0] rs1_ex,
    input  logic [4:0] rs2_ex,
    input  logic [4:0] rd_ex,
    input  logic       mem_read_ex,
    input  logic [4:0] rd_mem,
    input  logic       reg_write_mem,
    input  logic [4:0] rd_wb,
    input  logic       reg_write_wb,
    input  logic       branch_taken_ex,
    output logic       pc_write,
    output logic       if_id_write,
    output logic       if_id_flush,
    output logic       id_ex_flush,
    output logic [1:0] forward_a,
    output logic [1:0] forward_b,
    output logic       busy,
    output logic       halted
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
`endif
);
    typedef enum logic [1:0] {WARMUP, RUN, DRAIN, HALTED} state_t;
    state_t     state;
    logic [3:0] wcnt;
    logic [2:0] dcnt;
    logic       in_run, load_use, br, lu, hl;
    // RUN-state hazard arbitration: branch beats load-use beats halt
    always_comb begin
        in_run   = state == RUN;
        load_use = mem_read_ex && rd_ex != 5'd0 &&
                   ((use_rs1_id && rs1_id == rd_ex) || (use_rs2_id && rs2_id == rd_ex));
        br       = in_run && branch_taken_ex;
        lu       = in_run && !branch_taken_ex && load_use;
        hl       = in_run && !branch_taken_ex && !load_use && halt_id;
    end
    // Enables and flushes, zero latency from state and inputs
    always_comb begin
        pc_write    = in_run && !lu && !hl;
        if_id_write = in_run && !lu && !hl;
        if_id_flush = state == WARMUP || br;
        id_ex_flush = !in_run || br || lu || hl;
        busy        = state == WARMUP || state == DRAIN;
        halted      = state == HALTED;
    end
    // EX operand forwarding, MEM over WB, never from x0
    always_comb begin
        forward_a = (reg_write_mem && rd_mem != 5'd0 && rd_mem == rs1_ex) ? 2'b10 :
                    (reg_write_wb  && rd_wb  != 5'd0 && rd_wb  == rs1_ex) ? 2'b01 : 2'b00;
        forward_b = (reg_write_mem && rd_mem != 5'd0 && rd_mem == rs2_ex) ? 2'b10 :
                    (reg_write_wb  && rd_wb  != 5'd0 && rd_wb  == rs2_ex) ? 2'b01 : 2'b00;
    end
    // Sequencer: warm-up countdown, run, drain countdown, halt until reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= WARMUP;
            wcnt  <= 4'(WARMUP_CYCLES - 1);
            dcnt  <= 3'd0;
        end else begin
            case (state)
                WARMUP: if (wcnt == 4'd0) state <= RUN; else wcnt <= wcnt - 4'd1;
                RUN: if (hl) begin
                    state <= DRAIN;
                    dcnt  <= 3'(DRAIN_CYCLES - 1);
                end
                DRAIN: if (dcnt == 3'd0) state <= HALTED; else dcnt <= dcnt - 3'd1;
                default: state <= HALTED;
            endcase
        end
    end
`ifdef HAZARD_PERF_CNT_EN
    // Saturating counts of load-use stall cycles and branch flush cycles
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            stall_cnt <= (lu && !(&stall_cnt)) ? stall_cnt + 1'b1 : stall_cnt;
            flush_cnt <= (br && !(&flush_cnt)) ? flush_cnt + 1'b1 : flush_cnt;
        end
    end
`else
    logic unused_cnt_w;
    assign unused_cnt_w = |CNT_W;
`endif
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed test-plan cases plus randomized episodes against a timeline reference model
module tb_hazard_ctrl;
    localparam int W = 4;
    localparam int D = 3;
    localparam int CW = 4;
    logic clk = 0, rst = 1;
    logic [4:0] rs1_id, rs2_id, rs1_ex, rs2_ex, rd_ex, rd_mem, rd_wb;
    logic use_rs1_id, use_rs2_id, halt_id, mem_read_ex, reg_write_mem, reg_write_wb, branch_taken_ex;
    logic pc_write, if_id_write, if_id_flush, id_ex_flush, busy, halted;
    logic [1:0] forward_a, forward_b;
    logic [CW-1:0] stall_cnt, flush_cnt;
    int checks = 0, failures = 0;
    int cyc, halt_cyc, m_sc, m_fc;

    hazard_ctrl #(.WARMUP_CYCLES(W), .DRAIN_CYCLES(D), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .rs1_id(rs1_id), .rs2_id(rs2_id),
        .use_rs1_id(use_rs1_id), .use_rs2_id(use_rs2_id), .halt_id(halt_id),
        .rs1_ex(rs1_ex), .rs2_ex(rs2_ex), .rd_ex(rd_ex), .mem_read_ex(mem_read_ex),
        .rd_mem(rd_mem), .reg_write_mem(reg_write_mem), .rd_wb(rd_wb),
        .reg_write_wb(reg_write_wb), .branch_taken_ex(branch_taken_ex),
        .pc_write(pc_write), .if_id_write(if_id_write), .if_id_flush(if_id_flush),
        .id_ex_flush(id_ex_flush), .forward_a(forward_a), .forward_b(forward_b),
        .busy(busy), .halted(halted)
`ifdef HAZARD_PERF_CNT_EN
        , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
    );
`ifndef HAZARD_PERF_CNT_EN
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    function automatic logic [1:0] fwd(input logic [4:0] rs);
        if (reg_write_mem && rd_mem != 0 && rd_mem == rs) return 2'b10;
        if (reg_write_wb && rd_wb != 0 && rd_wb == rs) return 2'b01;
        return 2'b00;
    endfunction

    task automatic quiet();
        {rs1_id, rs2_id, rs1_ex, rs2_ex, rd_ex, rd_mem, rd_wb} = '0;
        {use_rs1_id, use_rs2_id, halt_id, mem_read_ex, reg_write_mem, reg_write_wb, branch_taken_ex} = '0;
    endtask

    task automatic randomize_inputs();
        rs1_id = 5'($urandom_range(0, 3)); rs2_id = 5'($urandom_range(0, 3));
        rs1_ex = 5'($urandom_range(0, 3)); rs2_ex = 5'($urandom_range(0, 3));
        rd_ex = 5'($urandom_range(0, 3)); rd_mem = 5'($urandom_range(0, 3)); rd_wb = 5'($urandom_range(0, 3));
        use_rs1_id = 1'($urandom); use_rs2_id = 1'($urandom); mem_read_ex = 1'($urandom);
        reg_write_mem = 1'($urandom); reg_write_wb = 1'($urandom);
        branch_taken_ex = $urandom_range(0, 7) == 0;
        halt_id = $urandom_range(0, 29) == 0;
    endtask

    // Called one time unit after a rising edge: checks the cycle, then advances the model across the next edge
    task automatic step();
        bit warm, hlt, drn, run, luc, br, lu, ha;
        #2;
        warm = cyc < W;
        hlt = halt_cyc >= 0 && cyc > halt_cyc + D;
        drn = halt_cyc >= 0 && cyc > halt_cyc && !hlt;
        run = !warm && halt_cyc < 0;
        luc = mem_read_ex && rd_ex != 0 && ((use_rs1_id && rs1_id == rd_ex) || (use_rs2_id && rs2_id == rd_ex));
        br = run && branch_taken_ex;
        lu = run && !branch_taken_ex && luc;
        ha = run && !branch_taken_ex && !luc && halt_id;
        check("pc_write", 32'(pc_write), 32'(run && !lu && !ha));
        check("if_id_write", 32'(if_id_write), 32'(run && !lu && !ha));
        check("if_id_flush", 32'(if_id_flush), 32'(warm || br));
        check("id_ex_flush", 32'(id_ex_flush), 32'(!run || br || lu || ha));
        check("busy", 32'(busy), 32'(warm || drn));
        check("halted", 32'(halted), 32'(hlt));
        check("forward_a", 32'(forward_a), 32'(fwd(rs1_ex)));
        check("forward_b", 32'(forward_b), 32'(fwd(rs2_ex)));
`ifdef HAZARD_PERF_CNT_EN
        check("stall_cnt", 32'(stall_cnt), 32'(m_sc));
        check("flush_cnt", 32'(flush_cnt), 32'(m_fc));
`endif
        if (ha) halt_cyc = cyc;
        if (lu && m_sc < (1 << CW) - 1) m_sc++;
        if (br && m_fc < (1 << CW) - 1) m_fc++;
        cyc++;
        @(posedge clk);
        #1;
    endtask

    // Asserts rst mid-cycle, checks the asynchronous reset values, releases after two edges
    task automatic do_reset();
        rst = 1;
        #2;
        check("rst_busy", 32'(busy), 32'd1);
        check("rst_halted", 32'(halted), 32'd0);
        check("rst_pc_write", 32'(pc_write), 32'd0);
        check("rst_if_id_write", 32'(if_id_write), 32'd0);
        check("rst_if_id_flush", 32'(if_id_flush), 32'd1);
        check("rst_id_ex_flush", 32'(id_ex_flush), 32'd1);
`ifdef HAZARD_PERF_CNT_EN
        check("rst_stall_cnt", 32'(stall_cnt), 32'd0);
        check("rst_flush_cnt", 32'(flush_cnt), 32'd0);
`endif
        cyc = 0; halt_cyc = -1; m_sc = 0; m_fc = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 0;
    endtask

    initial begin
        quiet();
        @(posedge clk);
        #1;
        do_reset();
        repeat (W + 1) step();
        rd_ex = 5; rs1_id = 5; use_rs1_id = 1; mem_read_ex = 1;
        step();
        quiet(); step();
        rs1_id = 0; use_rs1_id = 1; mem_read_ex = 1;
        step();
        rd_ex = 5; rs1_id = 5; use_rs1_id = 1; mem_read_ex = 1; halt_id = 1; branch_taken_ex = 1;
        step();
        quiet(); step();
        rs1_ex = 7; rd_mem = 7; reg_write_mem = 1; rd_wb = 7; reg_write_wb = 1;
        step();
        reg_write_mem = 0; step();
        rs2_ex = 0; rd_mem = 0; reg_write_mem = 1; step();
        quiet();
        rd_ex = 5; rs1_id = 5; use_rs1_id = 1; mem_read_ex = 1;
        repeat (20) step();
        quiet(); halt_id = 1; step();
        quiet(); repeat (D + 3) step();
        do_reset();
        repeat (W + 1) step();
        halt_id = 1; step();
        quiet(); repeat (2) step();
        do_reset();
        repeat (30) begin
            repeat ($urandom_range(10, 60)) begin
                randomize_inputs();
                step();
            end
            do_reset();
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
